// File: rtl/ps2_cmd_sequencer_if.sv
// Host-side command/reply handshake of the PS/2 command sequencer.
// The master drives commands and feeds back received bytes; the slave is the sequencer.
interface ps2_cmd_sequencer_if;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       done;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output cmd_byte, cmd_valid, rx_byte, rx_valid,
    input  cmd_ready, done, err_code, busy
  );

  modport slave (
    input  cmd_byte, cmd_valid, rx_byte, rx_valid,
    output cmd_ready, done, err_code, busy
  );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-device command transmitter: inhibit, request, shift a frame on device clock falls, check ACK and reply.
// Optional RESEND_RETRY_EN: resend the same byte on a 0xFE reply up to MAX_RETRY times.
module ps2_cmd_sequencer #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int EDGE_TIMEOUT   = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               ps2_clk_in,
  input  logic               ps2_data_in,
  output logic               ps2_clk_oe,
  output logic               ps2_data_oe,
  ps2_cmd_sequencer_if.slave host
);
  localparam int TMAX = (INHIBIT_CYCLES > EDGE_TIMEOUT) ? INHIBIT_CYCLES : EDGE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] EDGE_LAST = TW'(EDGE_TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NOACK   = 2'd2;
  localparam logic [1:0] ERR_NAK     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_LACK, S_RESP, S_DONE
  } state_t;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic [1:0]    err_q, err_d;
  logic          fall, data_s, edge_expired, is_nak;

`ifdef RESEND_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  // Idle pads are high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall         = clk_prev_q & ~clk_sync_q[1];
  assign data_s       = data_sync_q[1];
  assign edge_expired = (timer_q == EDGE_LAST);
  assign is_nak       = host.rx_valid & ((host.rx_byte == 8'hFE) | (host.rx_byte == 8'hFC));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      err_q     <= ERR_OK;
`ifdef RESEND_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      err_q     <= err_d;
`ifdef RESEND_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    err_d     = err_q;
`ifdef RESEND_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid) begin
          // Frame = {stop, odd parity, data}; shifted out LSB first.
          frame_d   = {1'b1, ~^host.cmd_byte, host.cmd_byte};
          err_d     = ERR_OK;
          timer_d   = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
`ifdef RESEND_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = S_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REQ: begin
        bit_cnt_d = '0;
        timer_d   = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          data_oe_d = ~frame_q[bit_cnt_q];
          timer_d   = '0;
          if (bit_cnt_q == 4'd9) state_d = S_LACK;
        end else if (edge_expired) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = ERR_TIMEOUT;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LACK: begin
        if (fall) begin
          timer_d = '0;
          if (!data_s) begin
            state_d = S_RESP;
          end else begin
            err_d   = ERR_NOACK;
            state_d = S_DONE;
          end
        end else if (edge_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (host.rx_valid && host.rx_byte == 8'hFA) begin
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if (is_nak) begin
`ifdef RESEND_RETRY_EN
          if (host.rx_byte == 8'hFE && retry_q < RW'(MAX_RETRY)) begin
            retry_d  = retry_q + 1'b1;
            timer_d  = '0;
            clk_oe_d = 1'b1;
            state_d  = S_INHIBIT;
          end else begin
            err_d   = ERR_NAK;
            state_d = S_DONE;
          end
`else
          err_d   = ERR_NAK;
          state_d = S_DONE;
`endif
        end else if (edge_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_data_oe    = data_oe_q;
  assign host.cmd_ready = (state_q == S_IDLE);
  assign host.busy      = (state_q != S_IDLE);
  assign host.done      = (state_q == S_DONE);
  assign host.err_code  = err_q;
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench for ps2_cmd_sequencer: an open-collector PS/2 device model clocks frames,
// the stimulus queues expected results, and a monitor checks them on every done pulse.
`timescale 1ns/1ps
module tb_ps2_cmd_sequencer;
  localparam int INHIBIT = 5000;
  localparam int ETO     = 2000;
  localparam int HALF    = 20;

  typedef struct {
    logic [7:0] cmd;
    logic [1:0] err;
    int         frames;
    logic [9:0] frame;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_L;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_line, ps2_data_line;
  logic dev_clk_pull = 1'b0, dev_data_pull = 1'b0;
  logic dev_rx_valid = 1'b0, tb_rx_valid = 1'b0;
  logic [7:0] dev_rx_byte = 8'h00, tb_rx_byte = 8'h00;
  logic dev_clocks = 1'b1, dev_ack = 1'b1, dev_record = 1'b1;
  int   dev_falls = 0;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];
  logic [7:0] reply_q[$];

  int checks = 0, failures = 0;
  int n_done = 0, n_acc = 0, cyc = 0, req_cyc = 0;

  ps2_cmd_sequencer_if bus();

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_pull);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_pull);
  assign bus.rx_valid  = dev_rx_valid | tb_rx_valid;
  assign bus.rx_byte   = tb_rx_valid ? tb_rx_byte : dev_rx_byte;

  ps2_cmd_sequencer #(
    .INHIBIT_CYCLES(INHIBIT),
    .EDGE_TIMEOUT  (ETO),
    .MAX_RETRY     (3)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .host       (bus.slave)
  );

  function automatic void chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endfunction

  // Device model: answers a request with 11 clock pulses, samples host bits on rising edges.
  initial begin
    logic [9:0] cap;
    logic rec, ack;
    forever begin
      @(negedge clk);
      if (reset_L && dev_clocks && ps2_data_oe && !ps2_clk_oe) begin
        rec = dev_record;
        ack = dev_ack;
        cap = '0;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
          dev_clk_pull = 1'b1;
          dev_falls++;
          repeat (HALF) @(negedge clk);
          dev_clk_pull = 1'b0;
          if (i <= 10) cap = {ps2_data_line, cap[9:1]};
          if (i == 10) begin
            if (rec) cap_q.push_back(cap);
            if (ack) dev_data_pull = 1'b1;
          end
          if (i == 11) dev_data_pull = 1'b0;
          repeat (HALF) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        if (reply_q.size() > 0) begin
          dev_rx_byte  = reply_q.pop_front();
          dev_rx_valid = 1'b1;
          @(negedge clk);
          dev_rx_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: inhibit length, start bit, accept count, and scoreboard compare on done.
  initial begin
    int   oe_run = 0;
    logic prev_clk_oe = 1'b0, prev_busy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_L) begin
        oe_run      = 0;
        prev_clk_oe = 1'b0;
        prev_busy   = 1'b0;
      end else begin
        if (ps2_clk_oe) begin
          oe_run++;
        end else if (prev_clk_oe) begin
          chk("inhibit_len", oe_run, INHIBIT);
          chk("start_bit_oe", ps2_data_oe, 1);
          oe_run  = 0;
          req_cyc = cyc;
        end
        prev_clk_oe = ps2_clk_oe;
        if (bus.busy && !prev_busy) n_acc++;
        prev_busy = bus.busy;
        if (bus.done) begin
          n_done++;
          chk("ready_in_done", bus.cmd_ready, 0);
          if (exp_q.size() == 0) begin
            chk("spurious_done", bus.done, 0);
          end else begin
            e = exp_q.pop_front();
            chk("err_code", bus.err_code, e.err);
            chk("oe_at_done", {ps2_clk_oe, ps2_data_oe}, 0);
            chk("frame_count", cap_q.size(), e.frames);
            while (cap_q.size() > 0) chk("frame_bits", cap_q.pop_front(), e.frame);
            if (e.lat >= 0) chk("timeout_latency", cyc - req_cyc, e.lat);
            $display("txn cmd=%02h err=%0d expected_err=%0d frames=%0d", e.cmd, bus.err_code, e.err, e.frames);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] b, input logic [1:0] err, input int frames,
                          input logic [9:0] frame, input int lat);
    exp_t e;
    e.cmd = b; e.err = err; e.frames = frames; e.frame = frame; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] err, input int frames,
                      input logic [9:0] frame, input int lat);
    push_exp(b, err, frames, frame, lat);
    bus.cmd_byte  = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Returns at the negedge where done is high, or after the cycle budget.
  task automatic wait_done(input string name);
    int guard = 0;
    logic seen = 1'b0;
    while (!seen && guard < 60000) begin
      @(negedge clk);
      guard++;
      seen = bus.done;
    end
    chk({name, "_done_seen"}, seen, 1);
  endtask

  initial begin
    int acc0, base, guard;
    reset_L       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h00;
    #2 reset_L = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_busy", bus.busy, 0);
    reset_L = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: data 1,0,1,1,0,1,1,1, parity 1, stop 1 -> frame 0x3ED, reply 0xFA
    dev_ack = 1'b1;
    reply_q.push_back(8'hFA);
    send(8'hED, 2'd0, 1, 10'h3ED, -1);
    wait_done("set_leds");
    repeat (5) @(negedge clk);

    // 0xFF with a silent device: SHIFT waits ETO cycles after the REQ cycle, then DONE
    dev_clocks = 1'b0;
    send(8'hFF, 2'd1, 0, 10'h000, ETO + 1);
    wait_done("timeout");
    dev_clocks = 1'b1;
    repeat (5) @(negedge clk);

    // 0x00 without line ACK: parity 1 -> frame 0x300
    dev_ack = 1'b0;
    send(8'h00, 2'd2, 1, 10'h300, -1);
    wait_done("no_ack");
    dev_ack = 1'b1;
    repeat (5) @(negedge clk);

    // 0xF4 (five ones, parity 0 -> frame 0x2F4) answered FE, FE, FA
    reply_q.push_back(8'hFE);
    reply_q.push_back(8'hFE);
    reply_q.push_back(8'hFA);
`ifdef RESEND_RETRY_EN
    send(8'hF4, 2'd0, 3, 10'h2F4, -1);
`else
    send(8'hF4, 2'd3, 1, 10'h2F4, -1);
`endif
    wait_done("resend");
    reply_q.delete();
    repeat (5) @(negedge clk);

    // Stray 0xFA in IDLE must not produce a done
    tb_rx_byte  = 8'hFA;
    tb_rx_valid = 1'b1;
    @(negedge clk);
    tb_rx_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_rx_no_done", n_done, 4);
    chk("idle_rx_busy", bus.busy, 0);

    // cmd_valid held through a whole 0xF2 transaction (parity 0 -> frame 0x2F2)
    acc0 = n_acc;
    push_exp(8'hF2, 2'd0, 1, 10'h2F2, -1);
    reply_q.push_back(8'hFA);
    bus.cmd_byte  = 8'hF2;
    bus.cmd_valid = 1'b1;
    wait_done("held_valid");
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("single_accept", n_acc - acc0, 1);

    // Reset at the 5th device clock fall while sending 0x00
    dev_record    = 1'b0;
    base          = dev_falls;
    bus.cmd_byte  = 8'h00;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (dev_falls < base + 5 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("fifth_fall_reached", (dev_falls >= base + 5), 1);
    chk("pre_reset_data_oe", ps2_data_oe, 1);
    reset_L = 1'b0;
    #1;
    chk("midframe_rst_clk_oe", ps2_clk_oe, 0);
    chk("midframe_rst_data_oe", ps2_data_oe, 0);
    repeat (3) @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    repeat (1500) @(negedge clk);

    chk("done_total", n_done, 5);
    chk("accept_total", n_acc, 6);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
